inv_keyexpansion: RTL and testbench
===================================

# inv_keyexpansion

Inverse AES-128 key schedule: takes the final (round-10) round key and regenerates round keys 10 down to 0, one round per clock. It is the reverse-direction companion of `keyexpansion` and feeds the decryption datapath, which consumes round keys last-first. The full schedule is also presented in the same 1408-bit bundle layout that `keyexpansion` produces, so either block can drive a consumer.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_last`  in  128  round-10 key. Word w40 is in [127:96] and w43 in [31:0]; byte 0 is the MSB.
- `start`  in  1  single-cycle request. Sampled only in IDLE or DONE.
- `rk_valid`  out  1  high for exactly the cycle in which `rk`/`rk_round` carry a new round key.
- `rk_round`  out  4  index of the round key currently on `rk` (10..0).
- `rk`  out  128  current round key, same word/byte order as `key_last`.
- `finish`  out  1  level. High in DONE, when all 11 round keys are valid in `out`.
- `out`  out  1408  full schedule. Round key r is at out[1407-128*r -: 128]: round 0 in the MSBs, round 10 in the LSBs.

## Operation
- States:
  - IDLE: reset state.
  - RUN: computes one round per cycle.
  - DONE: schedule complete.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(round counter reaches 0)--> DONE.
  - DONE --start--> RUN. This is a restart with new `key_last`; `finish` drops the same edge.
- Start edge:
  - Latch `key_last` into the working register K and into the round-10 slot of `out`.
  - Set round counter r=10.
  - Drive `rk`=key_last, `rk_round`=10, `rk_valid`=1.
- Each RUN cycle, with K={a,b,c,d} holding round key r:
  - d'=d^c, c'=c^b, b'=b^a.
  - a'=a ^ SubWord(RotWord(d')) ^ {Rcon[r],24'h0}.
  - RotWord rotates one byte left, {b0,b1,b2,b3}->{b1,b2,b3,b0}.
  - SubWord is the forward S-box on each of the 4 bytes.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Register updates per RUN cycle:
  - K<={a',b',c',d'}.
  - Round slot r-1 of `out` <= the new key.
  - r<=r-1.
  - `rk`<=new key, `rk_round`<=r-1, `rk_valid`<=1.
- When r-1 == 0, the next state is DONE.
- In DONE, `rk_valid`=0. `out` and `rk` hold their values.
- `start` in RUN is ignored: no restart, no effect on the sequence.
- `start` in IDLE or DONE while `key_last` changes: only the value sampled on the start edge is used. Later changes to `key_last` are ignored.
- Reset asserted mid-RUN: everything returns to reset values immediately, with no partial finish. The next start after release behaves as from IDLE.
- Reset values:
  - state=IDLE, r=0, K=0.
  - `out`=0, `rk`=0, `rk_round`=0, `rk_valid`=0, `finish`=0.

## Timing
- All outputs are registered. There is no combinational path from `start` or `key_last` to any output.
- Relative to the edge that samples `start` (edge 0):
  - Edge 0: round 10 appears on `rk`, `rk_valid`=1.
  - Edges 1..10: rounds 9..0 appear; `rk_valid` stays high for 11 consecutive cycles.
  - Edge 11: `finish` rises and `rk_valid` falls.
- `out` slot r is valid from the cycle after edge 10-r and stays stable until the next accepted start or reset.
- Back-to-back: a start sampled in the first DONE cycle begins a new sequence on that edge. `finish` is then high for exactly one cycle.
- Critical path: 4 parallel S-box lookups plus a 3-input XOR per byte.

## Structure
- Shared header `aes_defs.vh`, shared with `keyexpansion` and the cipher cores:
  - Nk, Nr, and the round-key width (128) and schedule width (1408).
  - Rcon table.
  - State encodings for IDLE/RUN/DONE.
- Sub-module `sbox`: an 8-bit combinational forward S-box, reused from the encryption path. Instantiate it 4 times for SubWord.
- Everything else stays in one module: FSM, round counter, Rcon lookup, XOR network, `out` slot writes.

## Test plan
- FIPS-197 A.1 vector.
  - Stimulus: `key_last`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: round 0 = 2b7e151628aed2a6abf7158809cf4f3c, round 9 = ac7766f319fadc2128d12941575c006e.
  - `finish` exactly 11 cycles after the start edge.
- Round trip.
  - Stimulus: run `keyexpansion` on key 6578 7061 6e64 2033 322d 6279 7465 206b, and feed its round 10 to `key_last`.
  - Required: `out` equals the `keyexpansion` `out` bit-for-bit.
- Stream check.
  - Required: `rk_valid` high for exactly 11 cycles, `rk_round` sequence 10,9,...,0.
  - Each `rk` matches the corresponding `out` slot.
- Start during RUN.
  - Stimulus: pulse `start` at RUN cycle 4 with a different `key_last`.
  - Required: the sequence and result are unchanged from the original key.
- Reset mid-operation.
  - Stimulus: assert `rst` low at RUN cycle 5.
  - Required: all outputs are 0 within the same cycle and `finish` never pulses.
  - After release plus start, the A.1 result is correct.
- Restart from DONE.
  - Stimulus: second start in the first DONE cycle with an all-zero `key_last`.
  - Required: `finish` drops the same edge, and a new 11-cycle sequence runs with round 0 computed from the zero key.

Source files
------------

// File: rtl/inv_keyexpansion_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM encoding, forward S-box table and Rcon.
package inv_keyexpansion_pkg;

   localparam int NK      = 4;
   localparam int NR      = 10;
   localparam int RK_W    = 128;
   localparam int SCHED_W = 1408;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Forward S-box, entry 0x00 in the MSBs.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/inv_keyexpansion_sbox.sv
// 8-bit combinational forward AES S-box.
module inv_keyexpansion_sbox
   import inv_keyexpansion_pkg::*;
(
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);

   assign sub_val = SBOX_TABLE[11'd2047 - {byte_val, 3'b000} -: 8];

endmodule

// File: rtl/inv_keyexpansion.sv
// Inverse AES-128 key schedule: regenerates round keys 10..0 from the round-10 key, one per clock,
// streaming each on rk and collecting the full schedule in out.
module inv_keyexpansion
   import inv_keyexpansion_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [RK_W-1:0]      key_last,
   input  logic                 start,
   output logic                 rk_valid,
   output logic [3:0]           rk_round,
   output logic [RK_W-1:0]      rk,
   output logic                 finish,
   output logic [SCHED_W-1:0]   out
);

   state_t              state_r, state_next_s;
   logic [3:0]          round_r, round_next_s;
   logic [RK_W-1:0]     key_r, key_next_s, new_key_s;
   logic [RK_W-1:0]     rk_next_s;
   logic [3:0]          rk_round_next_s;
   logic [SCHED_W-1:0]  out_next_s;

   logic [31:0] a_s, b_s, c_s, d_s;
   logic [31:0] a_new_s, b_new_s, c_new_s, d_new_s;
   logic [31:0] rot_s, sub_s;

   assign {a_s, b_s, c_s, d_s} = key_r;

   // Undo the forward XOR chain; d' is w[4r-1], which feeds the SubWord term.
   assign d_new_s   = d_s ^ c_s;
   assign c_new_s   = c_s ^ b_s;
   assign b_new_s   = b_s ^ a_s;
   assign rot_s     = {d_new_s[23:0], d_new_s[31:24]};
   assign a_new_s   = a_s ^ sub_s ^ {rcon(round_r), 24'h000000};
   assign new_key_s = {a_new_s, b_new_s, c_new_s, d_new_s};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      inv_keyexpansion_sbox u_sbox (
         .byte_val (rot_s[31-8*g -: 8]),
         .sub_val  (sub_s[31-8*g -: 8])
      );
   end

   // Next-state, working key, round counter and schedule slot writes.
   always_comb begin
      state_next_s    = state_r;
      round_next_s    = round_r;
      key_next_s      = key_r;
      rk_next_s       = rk;
      rk_round_next_s = rk_round;
      out_next_s      = out;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next_s     = ST_RUN;
               round_next_s     = LAST_ROUND;
               key_next_s       = key_last;
               rk_next_s        = key_last;
               rk_round_next_s  = LAST_ROUND;
               out_next_s[RK_W-1:0] = key_last;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_RUN: begin
            // Counter at 0 means round 0 is already out; this cycle only retires the run.
            if (round_r == 4'd0) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s    = ST_RUN;
               round_next_s    = round_r - 4'd1;
               key_next_s      = new_key_s;
               rk_next_s       = new_key_s;
               rk_round_next_s = round_r - 4'd1;
               for (int i = 0; i < 11; i++) begin
                  out_next_s[SCHED_W-1-RK_W*i -: RK_W] =
                     (i == int'(round_r) - 1) ? new_key_s : out[SCHED_W-1-RK_W*i -: RK_W];
               end
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; valid/finish are decoded from the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         round_r  <= 4'd0;
         key_r    <= '0;
         rk       <= '0;
         rk_round <= 4'd0;
         rk_valid <= 1'b0;
         finish   <= 1'b0;
         out      <= '0;
      end else begin
         state_r  <= state_next_s;
         round_r  <= round_next_s;
         key_r    <= key_next_s;
         rk       <= rk_next_s;
         rk_round <= rk_round_next_s;
         rk_valid <= (state_next_s == ST_RUN);
         finish   <= (state_next_s == ST_DONE);
         out      <= out_next_s;
      end
   end

endmodule

// File: tb/tb_inv_keyexpansion.sv
// Scoreboard bench for inv_keyexpansion: FIPS-197 A.1, round trip, restart, start-in-RUN, reset-in-RUN.
module tb_inv_keyexpansion;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [127:0]   key_last = '0;
   logic           start = 1'b0;
   logic           rk_valid;
   logic [3:0]     rk_round;
   logic [127:0]   rk;
   logic           finish;
   logic [1407:0]  out_bus;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]   rnd;
      logic [127:0] key;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] sbox_m [256];
   logic [7:0] rcon_m [11];

   localparam logic [1407:0] A1_SCHED = {
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RT_KEY  = 128'h657870616e642033322d62797465206b;

   inv_keyexpansion dut (
      .clk      (clk),
      .rst      (rst),
      .key_last (key_last),
      .start    (start),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk       (rk),
      .finish   (finish),
      .out      (out_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      logic [7:0] a = x;
      logic [7:0] b = y;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from GF(2^8) inversion plus the affine map.
   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_m[x] = s;
      end
      rcon_m[0] = 8'h00;
      rcon_m[1] = 8'h01;
      for (int i = 2; i < 11; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
   endtask

   function automatic logic [31:0] sub_rot(input logic [31:0] w, input int rnd);
      logic [31:0] r = {w[23:0], w[31:24]};
      return {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]}
             ^ {rcon_m[rnd], 24'h000000};
   endfunction

   function automatic logic [1407:0] fwd_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [1407:0] s;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++)
         w[i] = w[i-4] ^ ((i % 4 == 0) ? sub_rot(w[i-1], i / 4) : w[i-1]);
      for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
      return s;
   endfunction

   // Word-by-word backward recurrence w[i-4] = w[i] ^ f(w[i-1]).
   function automatic logic [1407:0] inv_expand(input logic [127:0] last);
      logic [31:0] w [44];
      logic [1407:0] s;
      for (int i = 0; i < 4; i++) w[40+i] = last[127-32*i -: 32];
      for (int i = 43; i >= 4; i--)
         w[i-4] = w[i] ^ ((i % 4 == 0) ? sub_rot(w[i-1], i / 4) : w[i-1]);
      for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
      return s;
   endfunction

   // Monitor: every valid round key is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rk_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stray_rk: got round %0d key %h, expected none", rk_round, rk);
         end else begin
            e = exp_q.pop_front();
            if (rk_round !== e.rnd || rk !== e.key) begin
               errors++;
               $display("FAIL rk_stream: got round %0d key %h, expected round %0d key %h",
                        rk_round, rk, e.rnd, e.key);
            end
         end
      end
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic run_seq(input logic [127:0] kl, input logic [1407:0] exp_s,
                          input int pulse_at, input string name);
      int cnt;
      for (int r = 10; r >= 0; r--)
         exp_q.push_back(exp_t'{4'(r), exp_s[1407-128*r -: 128]});
      key_last = kl;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      key_last = ~kl;
      check({name, "_finish_drop"}, 128'(finish), 128'd0);
      cnt = 0;
      while (!finish && cnt < 40) begin
         if (cnt == pulse_at) begin
            start    = 1'b1;
            key_last = 128'hffffffffffffffffffffffffffffffff;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      check({name, "_finish_latency"}, 128'(cnt), 128'd11);
      check({name, "_valid_low"}, 128'(rk_valid), 128'd0);
      check({name, "_stream_complete"}, 128'(exp_q.size()), 128'd0);
      for (int r = 0; r < 11; r++)
         check($sformatf("%s_out_slot%0d", name, r), out_bus[1407-128*r -: 128],
               exp_s[1407-128*r -: 128]);
   endtask

   initial begin
      build_tables();
      repeat (3) @(negedge clk);
      check("reset_rk", rk, 128'd0);
      check("reset_ctl", {rk_valid, finish, rk_round}, 128'd0);
      check("reset_out_or", 128'(|out_bus), 128'd0);
      rst = 1'b1;
      @(negedge clk);

      // FIPS-197 A.1 from IDLE, then immediate restart from the first DONE cycle with a zero key.
      run_seq(A1_LAST, A1_SCHED, -1, "a1");
      run_seq(128'd0, inv_expand(128'd0), -1, "zero_restart");

      repeat (3) @(negedge clk);
      check("done_hold_finish", 128'(finish), 128'd1);
      run_seq(fwd_expand(RT_KEY)[127:0], fwd_expand(RT_KEY), -1, "round_trip");

      repeat (2) @(negedge clk);
      run_seq(A1_LAST, A1_SCHED, 4, "start_in_run");

      // Reset asserted during RUN cycle 5.
      repeat (2) @(negedge clk);
      for (int r = 10; r >= 0; r--)
         exp_q.push_back(exp_t'{4'(r), A1_SCHED[1407-128*r -: 128]});
      key_last = A1_LAST;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrun_rst_rk", rk, 128'd0);
      check("midrun_rst_ctl", {rk_valid, finish, rk_round}, 128'd0);
      check("midrun_rst_out_or", 128'(|out_bus), 128'd0);
      exp_q.delete();
      begin
         int fin_seen = 0;
         for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b1;
            if (finish) fin_seen++;
         end
         check("midrun_no_finish", 128'(fin_seen), 128'd0);
      end
      run_seq(A1_LAST, A1_SCHED, -1, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
